// File: rtl/mult_div_unit_pkg.sv
// Shared op/state encodings, timing constants and op-decode helpers for the
// HI/LO multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } md_state_e;

    localparam int MUL_LATENCY = 2;
    localparam int DIV_ITERS   = 32;

    localparam logic [1:0] MULTEXT_NONE = 2'b00;
    localparam logic [1:0] MULTEXT_ADD  = 2'b01;
    localparam logic [1:0] MULTEXT_SUB  = 2'b10;

    function automatic logic is_div_op(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic [1:0] ext_of_op(input md_op_e op);
        case (op)
            OP_MADD, OP_MADDU: return MULTEXT_ADD;
            OP_MSUB, OP_MSUBU: return MULTEXT_SUB;
            default:           return MULTEXT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mult_div_unit_div.sv
// Iterative radix-2 restoring divider on 32-bit unsigned magnitudes.
// Loads on i_start, then performs one quotient bit per clock for DIV_ITERS clocks.
module div_radix2
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_abort,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

    logic        r_busy;
    logic [4:0]  r_count;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [32:0] w_shift;
    logic        w_ge;

    // Partial remainder shifted left with the next dividend bit taken from the quotient register.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_ge    = (w_shift >= {1'b0, r_div});

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_busy  <= 1'b0;
            r_count <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_count <= '0;
        end else if (r_busy) begin
            r_count <= r_count + 5'd1;
            if (r_count == LAST_ITER) begin
                r_busy <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before
    // being consumed, so only the control state above needs one.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (r_busy) begin
            r_quo <= {r_quo[30:0], w_ge};
            r_rem <= w_ge ? 32'(w_shift - {1'b0, r_div}) : w_shift[31:0];
        end
    end

    assign o_done      = r_busy && (r_count == LAST_ITER);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: single-cycle 32x32 multiply with optional
// accumulate/subtract, and a 32-iteration restoring divider with sign fix-up.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        Flush,
    input  logic        EXE_MultDivStart,
    input  logic [2:0]  EXE_MultDivOp,
    input  logic [31:0] EXE_OutA,
    input  logic [31:0] EXE_OutB,
    input  logic [31:0] HI_Rd,
    input  logic [31:0] LO_Rd,
    output logic        MULT_DIV_busy,
    output logic        MULT_DIV_finish,
    output logic [31:0] EXE_MULTDIVtoHI,
    output logic [31:0] EXE_MULTDIVtoLO,
    output logic [1:0]  EXE_MultiExtendOp
);

    md_state_e   r_state;
    md_state_e   w_next_state;
    md_op_e      r_op;
    md_op_e      w_in_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic [31:0] r_out_hi;
    logic [31:0] r_out_lo;
    logic [1:0]  r_out_ext;

    logic        w_accept;
    logic        w_in_signed;
    logic        w_div_start;
    logic        w_div_done;
    logic        w_finish;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_product;
    logic [63:0] w_mul_result;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_sign_hi;
    logic [31:0] w_sign_lo;

    assign w_in_op     = md_op_e'(EXE_MultDivOp);
    assign w_accept    = (r_state == IDLE) && EXE_MultDivStart && !Flush;
    assign w_in_signed = is_signed_op(w_in_op);
    assign w_div_start = w_accept && is_div_op(w_in_op);
    assign w_mag_a     = (w_in_signed && EXE_OutA[31]) ? -EXE_OutA : EXE_OutA;
    assign w_mag_b     = (w_in_signed && EXE_OutB[31]) ? -EXE_OutB : EXE_OutB;

    div_radix2 u_div (
        .clk         (clk),
        .rst         (rst),
        .i_abort     (Flush),
        .i_start     (w_div_start),
        .i_dividend  (w_mag_a),
        .i_divisor   (w_mag_b),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // NOTE: next state is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next_state = is_div_op(w_in_op) ? DIV : MUL;
            MUL:     w_next_state = DONE;
            DIV:     if (w_div_done) w_next_state = SIGN;
            SIGN:    w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (Flush) begin
            w_next_state = IDLE;
        end
    end

    // Sign-extending to 64 bits makes the truncated product correct for both signednesses.
    assign w_a_ext   = is_signed_op(r_op) ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
    assign w_b_ext   = is_signed_op(r_op) ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
    assign w_product = w_a_ext * w_b_ext;

    always_comb begin
        w_mul_result = w_product;
        case (ext_of_op(r_op))
            MULTEXT_ADD: w_mul_result = {r_acc_hi, r_acc_lo} + w_product;
            MULTEXT_SUB: w_mul_result = {r_acc_hi, r_acc_lo} - w_product;
            default:     w_mul_result = w_product;
        endcase
    end

    assign w_sign_a = is_signed_op(r_op) && r_a[31];
    assign w_sign_b = is_signed_op(r_op) && r_b[31];

    // A zero divisor bypasses sign correction so HI returns the raw dividend.
    always_comb begin
        w_sign_hi = w_sign_a ? -w_rem : w_rem;
        w_sign_lo = (w_sign_a ^ w_sign_b) ? -w_quo : w_quo;
        if (r_b == 32'd0) begin
            w_sign_hi = r_a;
            w_sign_lo = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_out_hi  <= '0;
            r_out_lo  <= '0;
            r_out_ext <= MULTEXT_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_finish) begin
                r_out_hi  <= r_res_hi;
                r_out_lo  <= r_res_lo;
                r_out_ext <= ext_of_op(r_op);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= w_in_op;
            r_a      <= EXE_OutA;
            r_b      <= EXE_OutB;
            r_acc_hi <= HI_Rd;
            r_acc_lo <= LO_Rd;
        end
        if (r_state == MUL) begin
            {r_res_hi, r_res_lo} <= w_mul_result;
        end else if (r_state == SIGN) begin
            r_res_hi <= w_sign_hi;
            r_res_lo <= w_sign_lo;
        end
    end

    assign w_finish          = (r_state == DONE) && !Flush && !rst;
    assign MULT_DIV_busy     = (r_state != IDLE);
    assign MULT_DIV_finish   = w_finish;
    assign EXE_MULTDIVtoHI   = w_finish ? r_res_hi : r_out_hi;
    assign EXE_MULTDIVtoLO   = w_finish ? r_res_lo : r_out_lo;
    assign EXE_MultiExtendOp = w_finish ? ext_of_op(r_op) : r_out_ext;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset; synchronous, active-high (sampled only on posedge clk).
REQ-003 Flush  input  1  abort any operation in flight; no finish is produced.
REQ-004 EXE_MultDivStart  input  1  one-cycle request to begin an operation; ignored unless idle.
REQ-005 EXE_MultDivOp  input  3  MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
REQ-006 EXE_OutA / EXE_OutB  input  32 each  rs and rt operands.
REQ-007 HI_Rd / LO_Rd  input  32 each  current HI/LO (bypassed) read values, used by the MADD/MSUB family.
REQ-008 MULT_DIV_busy  output  1  high from the cycle after start is accepted until the finish cycle inclusive.
REQ-009 MULT_DIV_finish  output  1  one-cycle pulse; result valid for commit to HI/LO.
REQ-010 EXE_MULTDIVtoHI / EXE_MULTDIVtoLO  output  32 each  final HI/LO values, accumulation already applied.
REQ-011 EXE_MultiExtendOp  output  2  00 = plain, 01 = MADD*, 10 = MSUB*; valid with finish.

Function
REQ-012 Start is accepted only in IDLE with Flush=0; operands, op, HI_Rd and LO_Rd are registered on the accepting edge.
REQ-013 States are IDLE, MUL, DIV, SIGN, DONE; IDLE goes to MUL (mult family) or DIV (div family).
REQ-014 MUL computes the 32x32 -> 64 product in one cycle: signed for MULT/MADD/MSUB, unsigned for the U variants; then DONE.
REQ-015 MADD* outputs {HI,LO} + product and MSUB* outputs {HI,LO} - product, both modulo 2^64, using the HI/LO values sampled at start.
REQ-016 DIV runs 32 radix-2 restoring iterations on magnitudes (unsigned operands for DIVU), then SIGN, then DONE.
REQ-017 SIGN stage: quotient sign = signA XOR signB, remainder sign = signA; LO = quotient, HI = remainder.
REQ-018 Latency from the accepting edge to finish high: mult family 2 cycles, div family 34 cycles.
REQ-019 DONE lasts exactly one cycle with finish=1, then returns to IDLE; outputs hold their last result until the next finish.
REQ-020 Divide by zero still takes the full 34 cycles and gives LO=0xFFFFFFFF and HI=dividend (unsigned path); for DIV the SIGN stage is skipped, so HI=EXE_OutA.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0x00000000, with no trap.
REQ-022 Flush in any state forces IDLE on the next edge, with busy=0 and finish=0; Flush in the DONE cycle suppresses finish.
REQ-023 Flush and start in the same cycle: Flush wins and nothing is accepted.
REQ-024 Start while busy is ignored; it is not queued.

Reset
REQ-025 rst=1 forces IDLE, busy=0, finish=0, EXE_MULTDIVtoHI=EXE_MULTDIVtoLO=0, EXE_MultiExtendOp=00, and clears the iteration counter.
REQ-026 rst mid-operation discards the operation; no finish follows.

Structure
REQ-027 Shared package holds the op enum (3 bits), the state enum, and the constants MUL_LATENCY=2, DIV_ITERS=32 and MULTEXT_NONE/ADD/SUB.
REQ-028 A single sub-module div_radix2 holds the iterative divider (start, 5-bit counter, done).

Verification
REQ-029 MULT 0xFFFFFFFF x 0x00000002 -> finish at cycle 2 with HI=0xFFFFFFFF, LO=0xFFFFFFFE, ExtendOp=00.
REQ-030 MADDU 0xFFFFFFFF x 0xFFFFFFFF with HI/LO=0/1 -> HI=0xFFFFFFFE, LO=0x00000002, ExtendOp=01.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> finish at cycle 34 with LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5 at cycle 34.
REQ-033 DIVU started, Flush at cycle 10 -> IDLE at cycle 11, no finish; a new MULT 3x4 gives LO=12 two cycles after it is accepted.
REQ-034 Start pulsed while busy in DIV -> ignored; exactly one finish pulse is seen.
